// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: serialises host commands onto the PLL LMMI port and
// sequences PLL reset, relock and debounced lock status.
module pll_reconfig_ctrl #(
  parameter int OFFSET_W     = 7,
  parameter int DATA_W       = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LMMI_TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WR,
  input  logic [OFFSET_W-1:0] CMD_OFFSET,
  input  logic [DATA_W-1:0]   CMD_WDATA,
  output logic                RSP_VALID,
  output logic [DATA_W-1:0]   RSP_RDATA,
  output logic                RSP_ERR,
  input  logic                RELOCK_REQ,
  output logic                LMMIREQUEST,
  output logic                LMMIWRRD_N,
  output logic [OFFSET_W-1:0] LMMIOFFSET,
  output logic [DATA_W-1:0]   LMMIWDATA,
  input  logic [DATA_W-1:0]   LMMIRDATA,
  input  logic                LMMIRDATAVALID,
  input  logic                LMMIREADY,
  output logic                PLLRESET,
  input  logic                LOCK,
  output logic                LOCKED,
  output logic                LOCK_ERR
);

  localparam int M1 =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX =
    (M1 > LMMI_TIMEOUT) ? M1 : LMMI_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LMMI_LAST = CW'(LMMI_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CMAX);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [SW-1:0] STB_SAT   = SW'(LOCK_STABLE);

  typedef enum logic [2:0] {
    PRST, WLOCK, IDLE, REQ, WRD, RESP
  } state_t;

  state_t state, nxt;

  logic [CW-1:0] cnt, cnt_d;
  logic [SW-1:0] stable, stable_d;

  logic                ready_q, ready_d;
  logic                req_q, req_d;
  logic                prst_q, prst_d;
  logic                rvalid_q, rvalid_d;
  logic                rerr_q, rerr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                locked_q, locked_d;
  logic                lerr_q, lerr_d;
  logic                wrrd_q, wrrd_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic lock_hit;
  logic monitored;
  logic xfer_ok;

  assign lock_hit  = LOCK && (stable == STB_LAST);
  assign monitored = (state == IDLE) || (state == REQ) ||
                     (state == WRD)  || (state == RESP);
  assign xfer_ok   = ((state == REQ) && LMMIREADY) ||
                     ((state == WRD) && LMMIRDATAVALID);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= PRST;
      cnt      <= '0;
      stable   <= '0;
      ready_q  <= 1'b0;
      req_q    <= 1'b0;
      prst_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      locked_q <= 1'b0;
      lerr_q   <= 1'b0;
      wrrd_q   <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_d;
      stable   <= stable_d;
      ready_q  <= ready_d;
      req_q    <= req_d;
      prst_q   <= prst_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      locked_q <= locked_d;
      lerr_q   <= lerr_d;
      wrrd_q   <= wrrd_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      PRST:
        if (cnt == RST_LAST) nxt = WLOCK;
      WLOCK:
        if (lock_hit || cnt == LOCK_LAST) nxt = IDLE;
      IDLE:
        if (RELOCK_REQ) nxt = PRST;
        else if (CMD_VALID) nxt = REQ;
      REQ:
        if (LMMIREADY) nxt = wrrd_q ? RESP : WRD;
        else if (cnt == LMMI_LAST) nxt = RESP;
      WRD:
        if (LMMIRDATAVALID || cnt == LMMI_LAST) nxt = RESP;
      RESP:
        nxt = IDLE;
      default:
        nxt = PRST;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    cnt_d = '0;
    if (nxt == state)
      cnt_d = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    stable_d = '0;
    if (state == WLOCK && LOCK)
      stable_d = (stable == STB_SAT) ? stable : stable + 1'b1;

    locked_d = locked_q;
    lerr_d   = lerr_q;
    if (monitored && locked_q && !LOCK) begin
      locked_d = 1'b0;
      lerr_d   = 1'b1;
    end
    if (state == IDLE && nxt == PRST)
      locked_d = 1'b0;
    if (state == WLOCK && nxt == IDLE) begin
      locked_d = lock_hit;
      lerr_d   = !lock_hit;
    end

    wrrd_d  = wrrd_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    if (state == IDLE && nxt == REQ) begin
      wrrd_d  = CMD_WR;
      off_d   = CMD_OFFSET;
      wdata_d = CMD_WDATA;
    end

    ready_d  = (nxt == IDLE);
    req_d    = (nxt == REQ);
    prst_d   = (nxt == PRST);
    rvalid_d = (nxt == RESP);
    rerr_d   = (nxt == RESP) && !xfer_ok;
    rdata_d  = '0;
    if (nxt == RESP && state == WRD && LMMIRDATAVALID)
      rdata_d = LMMIRDATA;
  end

  assign CMD_READY   = ready_q;
  assign LMMIREQUEST = req_q;
  assign LMMIWRRD_N  = wrrd_q;
  assign LMMIOFFSET  = off_q;
  assign LMMIWDATA   = wdata_q;
  assign PLLRESET    = prst_q;
  assign RSP_VALID   = rvalid_q;
  assign RSP_ERR     = rerr_q;
  assign RSP_RDATA   = rdata_q;
  assign LOCKED      = locked_q;
  assign LOCK_ERR    = lerr_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed and random stimulus checked every cycle
// against a phase-level reference model of the controller.
module tb_pll_reconfig_ctrl;

  localparam int OW   = 7;
  localparam int DW   = 8;
  localparam int RSTC = 16;
  localparam int STAB = 64;
  localparam int LTO  = 500;
  localparam int MTO  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid;
  logic          cmd_wr;
  logic [OW-1:0] cmd_offset;
  logic [DW-1:0] cmd_wdata;
  logic          relock_req;
  logic [DW-1:0] lmmi_rdata;
  logic          lmmi_rdatavalid;
  logic          lmmi_ready;
  logic          lock;

  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          lmmi_request;
  logic          lmmi_wrrd_n;
  logic [OW-1:0] lmmi_offset;
  logic [DW-1:0] lmmi_wdata;
  logic          pllreset;
  logic          locked;
  logic          lock_err;

  pll_reconfig_ctrl #(
    .OFFSET_W(OW), .DATA_W(DW), .RST_CYCLES(RSTC),
    .LOCK_STABLE(STAB), .LOCK_TIMEOUT(LTO), .LMMI_TIMEOUT(MTO)
  ) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_WR(cmd_wr), .CMD_OFFSET(cmd_offset), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .RELOCK_REQ(relock_req),
    .LMMIREQUEST(lmmi_request), .LMMIWRRD_N(lmmi_wrrd_n),
    .LMMIOFFSET(lmmi_offset), .LMMIWDATA(lmmi_wdata),
    .LMMIRDATA(lmmi_rdata), .LMMIRDATAVALID(lmmi_rdatavalid),
    .LMMIREADY(lmmi_ready),
    .PLLRESET(pllreset), .LOCK(lock),
    .LOCKED(locked), .LOCK_ERR(lock_err)
  );

  typedef enum {
    M_RST, M_WAIT, M_IDLE, M_REQ, M_DATA, M_RESP
  } phase_t;

  phase_t        ph;
  int            elapsed;
  int            run;
  bit            m_ok;
  bit            m_locked;
  bit            m_err;
  bit            m_wr;
  bit            m_rsp_err;
  logic [OW-1:0] m_off;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus cycles spent in it.
  always @(posedge clk) begin
    phase_t np;
    int     done;
    if (rst) begin
      ph = M_RST; elapsed = 0; run = 0; m_ok = 1'b1;
      m_locked = 1'b0; m_err = 1'b0;
      m_wr = 1'b0; m_off = '0; m_wdata = '0;
      m_rsp_err = 1'b0; m_rdata = '0;
    end else begin
      done = elapsed + 1;
      np = ph;
      if (ph inside {M_IDLE, M_REQ, M_DATA, M_RESP} &&
          m_locked && !lock) begin
        m_locked = 1'b0; m_err = 1'b1;
      end
      case (ph)
        M_RST: if (done == RSTC) np = M_WAIT;
        M_WAIT: begin
          run = lock ? run + 1 : 0;
          if (run == STAB) begin
            np = M_IDLE; m_locked = 1'b1; m_err = 1'b0;
          end else if (done == LTO) begin
            np = M_IDLE; m_locked = 1'b0; m_err = 1'b1;
          end
        end
        M_IDLE: begin
          if (relock_req) begin
            np = M_RST; m_locked = 1'b0;
          end else if (cmd_valid) begin
            np = M_REQ; m_wr = cmd_wr;
            m_off = cmd_offset; m_wdata = cmd_wdata;
          end
        end
        M_REQ: begin
          if (lmmi_ready) begin
            if (m_wr) begin
              np = M_RESP; m_rsp_err = 1'b0; m_rdata = '0;
            end else np = M_DATA;
          end else if (done == MTO) begin
            np = M_RESP; m_rsp_err = 1'b1; m_rdata = '0;
          end
        end
        M_DATA: begin
          if (lmmi_rdatavalid) begin
            np = M_RESP; m_rsp_err = 1'b0; m_rdata = lmmi_rdata;
          end else if (done == MTO) begin
            np = M_RESP; m_rsp_err = 1'b1; m_rdata = '0;
          end
        end
        M_RESP: np = M_IDLE;
        default: np = M_RST;
      endcase
      elapsed = (np == ph) ? done : 0;
      if (np != ph) run = 0;
      ph = np;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               name, got, want, $time);
    end
  endtask

  task automatic tick();
    logic [5:0] got, want;
    @(posedge clk);
    #1;
    if (m_ok) begin
      got  = {cmd_ready, lmmi_request, pllreset,
              rsp_valid, locked, lock_err};
      want = {ph == M_IDLE, ph == M_REQ, ph == M_RST,
              ph == M_RESP, m_locked, m_err};
      chk("ctrl", 32'(got), 32'(want));
      if (ph == M_REQ)
        chk("lmmi", 32'({lmmi_wrrd_n, lmmi_offset, lmmi_wdata}),
            32'({m_wr, m_off, m_wdata}));
      if (ph == M_RESP)
        chk("rsp", 32'({rsp_err, rsp_rdata}),
            32'({m_rsp_err, m_rdata}));
    end
  endtask

  task automatic run_cmd(input  bit            wr,
                         input  logic [OW-1:0] off,
                         input  logic [DW-1:0] wd,
                         input  int            rdy_at,
                         input  int            vld_at,
                         input  logic [DW-1:0] rd,
                         input  int            budget,
                         output int            reqs,
                         output int            rsps,
                         output bit            err,
                         output logic [DW-1:0] data);
    int tail;
    reqs = 0; rsps = 0; err = 1'b0; data = '0; tail = -1;
    cmd_valid = 1'b1; cmd_wr = wr;
    cmd_offset = off; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < budget && tail != 0; k++) begin
      lmmi_ready = (k >= rdy_at);
      lmmi_rdatavalid = (k == vld_at);
      lmmi_rdata = rd;
      if (lmmi_request) reqs++;
      if (rsp_valid) begin
        rsps++; err = rsp_err; data = rsp_rdata;
        if (tail < 0) tail = 2;
      end
      tick();
      if (tail > 0) tail--;
    end
    lmmi_ready = 1'b0;
    lmmi_rdatavalid = 1'b0;
  endtask

  initial begin
    int            pr, lk_at, idle_at, reqs, rsps, lock_left;
    bit            err, lk_seen;
    logic [DW-1:0] data;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_offset = '0; cmd_wdata = '0; relock_req = 1'b0;
    lmmi_rdata = '0; lmmi_rdatavalid = 1'b0; lmmi_ready = 1'b0;
    lock = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Power-up: 16 reset cycles, then 64 stable LOCK cycles.
    pr = 0; lk_at = -1;
    for (int i = 0; i < 120; i++) begin
      if (pllreset) pr++;
      if (locked && lk_at < 0) lk_at = i;
      tick();
    end
    chk("prst_len", pr, 16);
    chk("lock_at", lk_at, 80);
    chk("lock_err0", 32'(lock_err), 0);

    run_cmd(1'b1, 7'h12, 8'hA5, 3, -1, 8'h00, 20,
            reqs, rsps, err, data);
    chk("wr_reqs", reqs, 4);
    chk("wr_rsps", rsps, 1);
    chk("wr_err", 32'(err), 0);

    run_cmd(1'b0, 7'h05, 8'h00, 0, 1, 8'h3C, 20,
            reqs, rsps, err, data);
    chk("rd_reqs", reqs, 1);
    chk("rd_rsps", rsps, 1);
    chk("rd_data", 32'(data), 32'h3C);
    chk("rd_err", 32'(err), 0);

    run_cmd(1'b1, 7'h40, 8'h5A, 1000, -1, 8'h00, 300,
            reqs, rsps, err, data);
    chk("to_reqs", reqs, 255);
    chk("to_rsps", rsps, 1);
    chk("to_err", 32'(err), 1);
    chk("to_data", 32'(data), 0);

    // Data valid only in the accept cycle must be ignored.
    run_cmd(1'b0, 7'h21, 8'h00, 0, 0, 8'h77, 300,
            reqs, rsps, err, data);
    chk("rdto_err", 32'(err), 1);
    chk("rdto_data", 32'(data), 0);

    // Relock with LOCK toggling every 10 cycles times out.
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    idle_at = -1; lk_seen = 1'b0;
    for (int i = 0; i < 600 && idle_at < 0; i++) begin
      lock = ((i / 10) % 2) == 0;
      if (locked) lk_seen = 1'b1;
      if (cmd_ready) idle_at = i;
      else tick();
    end
    chk("lto_idle", idle_at, 516);
    chk("lto_locked", 32'(lk_seen), 0);
    chk("lto_err", 32'(lock_err), 1);

    lock = 1'b1;
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    chk("err_sticky", 32'(lock_err), 1);
    lk_at = -1;
    for (int i = 0; i < 150 && lk_at < 0; i++) begin
      if (locked) lk_at = i;
      else tick();
    end
    chk("relock_at", lk_at, 80);
    chk("relock_err", 32'(lock_err), 0);

    // Relock beats a simultaneous command.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_offset = 7'h33;
    cmd_wdata = 8'h11; relock_req = 1'b1; lmmi_ready = 1'b1;
    tick();
    cmd_valid = 1'b0; relock_req = 1'b0;
    chk("both_out", 32'({cmd_ready, pllreset}), 32'b01);
    reqs = 0;
    for (int i = 0; i < 120 && !locked; i++) begin
      if (lmmi_request) reqs++;
      tick();
    end
    lmmi_ready = 1'b0;
    chk("both_reqs", reqs, 0);
    chk("both_lock", 32'(locked), 1);
    lock = 1'b0;
    tick();
    chk("loss", 32'({locked, lock_err}), 32'b01);
    lock = 1'b1;
    tick();

    lock_left = 0;
    for (int n = 0; n < 6000; n++) begin
      if (lock_left == 0) begin
        lock = !lock;
        lock_left = lock ? int'($urandom_range(40, 600))
                         : int'($urandom_range(1, 20));
      end
      lock_left--;
      rst = ($urandom_range(0, 1999) == 0);
      relock_req = ($urandom_range(0, 149) == 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wr = 1'($urandom_range(0, 1));
      cmd_offset = OW'($urandom);
      cmd_wdata = DW'($urandom);
      lmmi_ready = ($urandom_range(0, 2) == 0);
      lmmi_rdatavalid = ($urandom_range(0, 3) == 0);
      lmmi_rdata = DW'($urandom);
      tick();
    end

    rst = 1'b0; relock_req = 1'b0; cmd_valid = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Parametrised PLL reconfiguration and lock-management controller that sits between a host register port (CPU/JTAG bridge) and the PLL primitive's LMMI port, PLLRESET input and LOCK output. It serialises host read/write commands onto the LMMI handshake with timeout protection. It also sequences PLL reset and relock after power-up or on request, and filters LOCK into a debounced status. It generalises the bare PLL hookup to configurable offset/data widths, reset pulse length, lock-stable filtering and error reporting.

## Interface
Parameters:
- OFFSET_W, 7, LMMI offset width
- DATA_W, 8, LMMI data width
- RST_CYCLES, 16, PLLRESET pulse length in cycles (≥1)
- LOCK_STABLE, 64, consecutive LOCK-high cycles required before LOCKED asserts (≥1)
- LOCK_TIMEOUT, 65535, maximum cycles to wait for stable lock
- LMMI_TIMEOUT, 255, maximum cycles to wait for LMMIREADY or LMMIRDATAVALID

Ports:
- CLK  in  1  single clock, also drives LMMICLK externally
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  host command valid
- CMD_READY  out  1  controller can accept a command
- CMD_WR  in  1  1 = write, 0 = read
- CMD_OFFSET  in  OFFSET_W  register offset
- CMD_WDATA  in  DATA_W  write data
- RSP_VALID  out  1  one-cycle response strobe
- RSP_RDATA  out  DATA_W  read data (0 for writes/errors)
- RSP_ERR  out  1  response timed out
- RELOCK_REQ  in  1  pulse: reset PLL and wait for relock
- LMMIREQUEST  out  1  LMMI request
- LMMIWRRD_N  out  1  LMMI write (1) / read (0)
- LMMIOFFSET  out  OFFSET_W  LMMI offset
- LMMIWDATA  out  DATA_W  LMMI write data
- LMMIRDATA  in  DATA_W  LMMI read data
- LMMIRDATAVALID  in  1  LMMI read data valid
- LMMIREADY  in  1  LMMI ready/accept
- PLLRESET  out  1  PLL reset, active high
- LOCK  in  1  raw PLL lock
- LOCKED  out  1  filtered lock status
- LOCK_ERR  out  1  sticky: lock timeout or loss of lock; cleared by RST or successful relock

## Operation
- States: PRST, WLOCK, IDLE, REQ, WRD, RESP.
- RST forces PRST; counters cleared, all outputs 0 except PLLRESET=1.
- PRST: PLLRESET=1 for RST_CYCLES cycles, then → WLOCK.
- WLOCK: stable counter increments while LOCK=1, clears when LOCK=0. At LOCK_STABLE → IDLE, LOCKED=1, LOCK_ERR=0. If the timeout counter reaches LOCK_TIMEOUT first → IDLE, LOCKED=0, LOCK_ERR=1.
- IDLE: CMD_READY=1. Accept on CMD_VALID&CMD_READY and latch CMD_WR/OFFSET/WDATA → REQ. RELOCK_REQ in IDLE → PRST and clears LOCKED. RELOCK_REQ has priority over a simultaneous CMD_VALID, and the command is not accepted.
- REQ: LMMIREQUEST=1 with latched WRRD_N/OFFSET/WDATA held stable. The transfer is accepted on the first cycle with LMMIREQUEST&LMMIREADY. A write → RESP (ok). A read → WRD.
- WRD: LMMIREQUEST=0. First LMMIRDATAVALID → capture LMMIRDATA → RESP.
- Timeout in REQ or WRD: the counter reaches LMMI_TIMEOUT → drop request → RESP with RSP_ERR=1, RSP_RDATA=0.
- RESP: RSP_VALID=1 for one cycle → IDLE.
- Lock monitor:
  - In IDLE/REQ/WRD/RESP, LOCK=0 while LOCKED=1 deasserts LOCKED next cycle and sets LOCK_ERR.
  - No automatic relock.
  - LMMI commands are still serviced while unlocked.
- RELOCK_REQ outside IDLE is ignored. The host retries.
- Counters saturate. Width is clog2(max parameter + 1).

## Timing
- CMD_READY is low from the accept cycle until the cycle after RSP_VALID.
- Write with LMMIREADY already high: accept at cycle t, LMMIREQUEST at t+1, RSP_VALID at t+2.
- Read with LMMIREADY high at t+1 and LMMIRDATAVALID at t+2: capture at t+2, RSP_VALID at t+3.
- LMMIRDATAVALID in the same cycle as acceptance is not used. Data is only sampled in WRD.
- Timeout counters start at 0 on state entry and increment each cycle. Exactly LMMI_TIMEOUT waiting cycles precede the transition to RESP.
- PLLRESET is high for exactly RST_CYCLES cycles after RST deasserts or after RELOCK_REQ is taken.
- LOCKED asserts the cycle after the LOCK_STABLE-th consecutive LOCK-high cycle.
- RST mid-transaction: LMMIREQUEST drops in the next cycle. No RSP_VALID is issued for the aborted command.
- All outputs are registered.

## Test plan
- Reset release with LOCK high from cycle 0, RST_CYCLES=16, LOCK_STABLE=64 -> PLLRESET high for 16 cycles, LOCKED=1 exactly 64 cycles later, LOCK_ERR=0.
- Write offset 0x12, data 0xA5, LMMIREADY stalled 3 cycles -> LMMIREQUEST held 4 cycles with stable 0x12/0xA5; RSP_VALID=1, RSP_ERR=0.
- Read offset 0x05, RDATAVALID 2 cycles after accept with data 0x3C -> RSP_RDATA=0x3C, RSP_ERR=0, one-cycle RSP_VALID.
- LMMIREADY tied low, LMMI_TIMEOUT=255 -> request dropped after 255 cycles; RSP_VALID with RSP_ERR=1, RSP_RDATA=0.
- LOCK toggles every 10 cycles after PRST, LOCK_TIMEOUT=500 -> LOCKED stays 0; after 500 cycles IDLE with LOCK_ERR=1. A following RELOCK_REQ with steady LOCK clears LOCK_ERR and sets LOCKED.
- RELOCK_REQ and CMD_VALID in the same IDLE cycle -> relock taken, CMD_READY=0, no LMMI request. Then LOCK drops in IDLE -> LOCKED=0 and LOCK_ERR=1 next cycle.
